// File: rtl/mem_responder.sv
// Multi-cycle memory responder: serializes one read/write request at a time and
// completes it LATENCY cycles after acceptance, modelling memory latency for CPU stalls.
module mem_responder #(
  parameter int unsigned ADDR_W  = 13,
  parameter int unsigned LATENCY = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        wr,
  input  logic [15:0] addr,
  input  logic [15:0] data_in,
  output logic [15:0] data_out,
  output logic        data_valid,
  output logic        busy
);

  localparam int unsigned CNT_W = 4;
  localparam int unsigned DEPTH = 1 << ADDR_W;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               req_wr_q;
  logic [ADDR_W-1:0]  req_addr_q;
  logic [15:0]        req_data_q;
  logic [15:0]        mem_q [DEPTH];
  logic               busy_q, busy_d;
  logic               data_valid_q, data_valid_d;
  logic [15:0]        data_out_q, data_out_d;
  logic               accept_c;
  logic               complete_c;
  logic               unused_addr_c;

  assign accept_c      = (state_q == S_IDLE) && enable;
  assign complete_c    = (state_q == S_WAIT) && (cnt_q == '0);
  // Upper address bits are ignored so accesses wrap modulo the array size
  assign unused_addr_c = ^addr[15:ADDR_W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (enable) begin
          state_d = S_WAIT;
          cnt_d   = CNT_W'(LATENCY - 1);
        end
      end
      S_WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Read data is captured only on the completing edge; otherwise held
  always_comb begin
    busy_d       = (state_d == S_WAIT);
    data_valid_d = 1'b0;
    data_out_d   = data_out_q;
    if (complete_c && !req_wr_q) begin
      data_valid_d = 1'b1;
      data_out_d   = mem_q[req_addr_q];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q       <= 1'b0;
      data_valid_q <= 1'b0;
      data_out_q   <= '0;
    end else begin
      busy_q       <= busy_d;
      data_valid_q <= data_valid_d;
      data_out_q   <= data_out_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_wr_q   <= 1'b0;
      req_addr_q <= '0;
      req_data_q <= '0;
    end else if (accept_c) begin
      req_wr_q   <= wr;
      req_addr_q <= addr[ADDR_W-1:0];
      req_data_q <= data_in;
    end
  end

  // Array is not reset; a reset during WAIT returns state to IDLE so no commit happens
  always_ff @(posedge clk) begin
    if (complete_c && req_wr_q) begin
      mem_q[req_addr_q] <= req_data_q;
    end
  end

  assign busy       = busy_q;
  assign data_valid = data_valid_q;
  assign data_out   = data_out_q;

endmodule
